mem_stage_byte_ram_ctrl: RTL and testbench
==========================================

Name: mem_stage_byte_ram_ctrl

Overview:
- MEM-stage data memory controller, directly downstream of the execute stage.
- Consumes the effective address selected by execute (ALU result or load/store address) and the store data (Rd value).
- Backing store is a byte-wide RAM, big-endian; halfword/word accesses are sequenced one byte per cycle by an FSM, with a stall back to the pipeline.
- Returns load data extended to 32 bits for write-back.

Parameters:
- ADDR_W, 8: byte-address bits used; upper address bits are ignored.
- DEPTH, 256: RAM size in bytes; must equal 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  access request from execute
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready at a clk edge
- addr  in  32  effective byte address
- wdata  in  32  store data; right-aligned for byte/halfword
- rw  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- signed_ld  in  1  sign-extend byte/halfword loads
- rdata  out  32  registered load result
- done  out  1  one-cycle completion pulse
- stall  out  1  pipeline hold
- misalign_err  out  1  one-cycle pulse, coincident with done

Behaviour:
- Reset values: state=IDLE, beat=0, rdata=0, done=0, misalign_err=0, stall=0, req_ready=1. RAM contents are not reset.
- States:
  - IDLE: req_ready=1.
  - ACCESS: one RAM byte per cycle.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Acceptance (cycle T):
  - Latch addr[ADDR_W-1:0], wdata, rw, size, signed_ld.
  - Beat count n = 1, 2 or 4 for byte, halfword, word.
  - Next state ACCESS, beat=0. If the access is misaligned, next state DONE.
- Misaligned means any of: halfword with addr[0]=1; word with addr[1:0]!=0; size=11.
  - Misaligned: RAM is not touched, rdata=0, misalign_err=1 with done at T+1.
- ACCESS, beat i = 0..n-1, operating on byte address (addr+i) mod DEPTH:
  - Store: RAM[addr+i] <= byte (n-1-i) of wdata, i.e. the MSB goes to the lowest address.
  - Load: accumulator <= {acc[23:0], RAM[addr+i]}.
  - After beat n-1, go to DONE.
- Latency: beats occupy T+1..T+n; done is high at T+n+1.
- rdata update: loaded on the transition into DONE for loads, and held until the next completed load.
  - Byte: zero- or sign-extended from bit 7.
  - Halfword: zero- or sign-extended from bit 15.
  - Word: as assembled.
- Stores leave rdata unchanged.
- stall = 1 from the cycle after acceptance through the last ACCESS beat; 0 in IDLE and in DONE.
- req_valid is ignored while not in IDLE; requests are never queued. A request may be accepted in the cycle immediately after DONE.
- Address wrap: addr+i rolls modulo DEPTH. Only reachable via the low ADDR_W bits, since aligned accesses never cross a word.
- Reset mid-access: return to IDLE immediately and clear all outputs. Bytes already stored remain written; a partial load is discarded.
- Inputs other than req_valid may change freely after acceptance; only latched copies are used.

Optional Feature:
- Macro MEM_ACCESS_CNT_EN.
- When defined:
  - Adds output port access_cnt (16 bits), reset to 0.
  - Increments by 1 in each DONE cycle with misalign_err=0.
  - Saturates at 16'hFFFF.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Word store then load: store addr=0x10, wdata=0xDEADBEEF, size=10.
  - done at T+5; RAM[0x10..0x13] = DE, AD, BE, EF.
  - Loading the same address returns rdata=0xDEADBEEF; stall is high for 4 cycles.
- Byte sign extension: RAM[0x21]=0x80.
  - Byte load with signed_ld=1 gives rdata=0xFFFFFF80 at T+2.
  - Same load with signed_ld=0 gives 0x00000080.
- Halfword: store 0x00001234 at 0x30, then signed halfword load.
  - RAM[0x30]=12, RAM[0x31]=34; rdata=0x00001234; done at T+3.
- Misalignment: word load at 0x13 gives done and misalign_err at T+1, rdata=0, stall never asserted. size=11 at 0x00 gives the same response.
- Reset mid-store: assert reset during beat 2 of a word store of 0xAABBCCDD at 0x40.
  - Outputs are 0 and req_ready=1 immediately.
  - RAM[0x40]=AA and RAM[0x41]=BB are written; RAM[0x42..0x43] are unchanged.
- Back-to-back and busy handling:
  - Second req_valid held during ACCESS is ignored; it is accepted in the cycle after DONE.
  - With MEM_ACCESS_CNT_EN defined, access_cnt counts 2 after two good accesses and does not advance on a misaligned one.

Source files
------------

// File: rtl/mem_stage_byte_ram_ctrl.sv
// mem_stage_byte_ram_ctrl: MEM-stage data memory controller over a byte-wide,
// big-endian RAM. Halfword and word accesses take one RAM byte per cycle and
// hold the pipeline with stall while in flight. Load results are extended to
// 32 bits and registered for write-back.
// Optional feature: define MEM_ACCESS_CNT_EN to add the 16-bit access_cnt
// output, a saturating count of completed aligned accesses.
module mem_stage_byte_ram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        misalign_err
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [15:0] access_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rw_q, rw_d;
  logic [1:0]         size_q, size_d;
  logic               signed_q, signed_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mis_q, mis_d;
`ifdef MEM_ACCESS_CNT_EN
  logic [15:0]        cnt_q, cnt_d;
`endif

  logic [7:0]         mem [DEPTH];

  logic               req_misaligned;
  logic [1:0]         last_beat;
  logic [1:0]         byte_sel;
  logic [ADDR_W-1:0]  ram_addr;
  logic [7:0]         ram_wdata;
  logic [7:0]         rd_byte;
  logic               ram_we;
  logic [31:0]        acc_next;
  logic [31:0]        load_ext;
  logic               unused_addr_bits;

  // Upper address bits are deliberately ignored; only the low ADDR_W bits index the RAM.
  assign unused_addr_bits = ^addr[31:ADDR_W];

  // A request is misaligned if its size is reserved or it is not naturally aligned.
  assign req_misaligned = (size == 2'b11) ||
                          ((size == 2'b01) && addr[0]) ||
                          ((size == 2'b10) && (addr[1:0] != 2'b00));

  // Beat n-1 is the final beat; byte_sel walks from the MSB of wdata downwards.
  assign last_beat = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;
  assign byte_sel  = last_beat - beat_q;
  assign ram_addr  = addr_q + ADDR_W'(beat_q);
  assign ram_wdata = wdata_q[{byte_sel, 3'b000} +: 8];
  assign rd_byte   = mem[ram_addr];
  assign acc_next  = {acc_q[23:0], rd_byte};

  // Outputs are pure functions of state so an async reset clears them at once.
  assign req_ready    = (state_q == IDLE);
  assign stall        = (state_q == ACCESS);
  assign done         = (state_q == DONE);
  assign misalign_err = (state_q == DONE) && mis_q;
  assign rdata        = rdata_q;
`ifdef MEM_ACCESS_CNT_EN
  assign access_cnt   = cnt_q;
`endif

  // Extend the assembled load value according to the latched size and signedness.
  always_comb begin
    load_ext = acc_next;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & acc_next[7]}}, acc_next[7:0]};
      2'b01:   load_ext = {{16{signed_q & acc_next[15]}}, acc_next[15:0]};
      default: load_ext = acc_next;
    endcase
  end

  // Next-state logic: accept in IDLE, one byte per ACCESS beat, single-cycle DONE.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    size_d   = size_q;
    signed_d = signed_q;
    acc_d    = acc_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    ram_we   = 1'b0;
`ifdef MEM_ACCESS_CNT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = addr[ADDR_W-1:0];
          wdata_d  = wdata;
          rw_d     = rw;
          size_d   = size;
          signed_d = signed_ld;
          beat_d   = 2'd0;
          acc_d    = 32'h0;
          if (req_misaligned) begin
            mis_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = DONE;
          end else begin
            mis_d   = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        ram_we = rw_q;
        if (!rw_q) begin
          acc_d = acc_next;
        end
        if (beat_q == last_beat) begin
          state_d = DONE;
          if (!rw_q) begin
            rdata_d = load_ext;
          end
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef MEM_ACCESS_CNT_EN
        if (!mis_q && (cnt_q != 16'hFFFF)) begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rw_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      acc_q    <= 32'h0;
      rdata_q  <= 32'h0;
      mis_q    <= 1'b0;
`ifdef MEM_ACCESS_CNT_EN
      cnt_q    <= 16'h0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      acc_q    <= acc_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
`ifdef MEM_ACCESS_CNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Byte RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

endmodule

// File: tb/tb_mem_stage_byte_ram_ctrl.sv
// tb_mem_stage_byte_ram_ctrl: directed vector table, hand-written multi-cycle
// sequences and randomized accesses against a byte-array reference model.
module tb_mem_stage_byte_ram_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rw;
  logic [1:0]  size;
  logic        signed_ld;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        misalign_err;
`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] access_cnt;
`endif

  int compared;
  int mismatched;

  logic [7:0]  model_mem [256];
  logic [31:0] model_rdata;
  int          model_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_stall;
  } vec_t;

  vec_t vecs [22];

  mem_stage_byte_ram_ctrl #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .addr         (addr),
    .wdata        (wdata),
    .rw           (rw),
    .size         (size),
    .signed_ld    (signed_ld),
    .rdata        (rdata),
    .done         (done),
    .stall        (stall),
    .misalign_err (misalign_err)
`ifdef MEM_ACCESS_CNT_EN
    ,
    .access_cnt   (access_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference model: applies one access to the byte array with plain arithmetic.
  task automatic modelAccess(input logic [31:0] a_in, input logic [31:0] wd, input logic wr,
                             input logic [1:0] sz, input logic sgn,
                             output logic [31:0] exp_rdata, output logic exp_err,
                             output int exp_lat, output int exp_stall);
    int a;
    int n;
    logic [31:0] v;
    a = int'(a_in % 256);
    n = 1 << sz;
    if ((sz == 2'b11) || (a % n != 0)) begin
      model_rdata = 32'h0;
      exp_err     = 1'b1;
      exp_lat     = 1;
      exp_stall   = 0;
    end else begin
      exp_err   = 1'b0;
      exp_lat   = n + 1;
      exp_stall = n;
      if (wr) begin
        for (int i = 0; i < n; i++) begin
          model_mem[(a + i) % 256] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
        end
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
          v = v * 256 + 32'(model_mem[(a + i) % 256]);
        end
        if (sgn && (n == 1) && (v >= 32'd128))   v = v - 32'd256;
        if (sgn && (n == 2) && (v >= 32'h8000))  v = v - 32'h10000;
        model_rdata = v;
      end
      model_cnt++;
    end
    exp_rdata = model_rdata;
  endtask

  // Waits for done after an acceptance edge, measuring latency, stall and ready cycles.
  task automatic waitDone(output int lat, output int stalls, output int readies);
    lat     = 1;
    stalls  = 0;
    readies = 0;
    while (!done && lat < 20) begin
      if (stall)     stalls++;
      if (req_ready) readies++;
      tick();
      lat++;
    end
    if (!done) checkOutput("done_timeout", 32'(done), 32'h1);
  endtask

  // Issues one request from IDLE, scrambles the inputs after acceptance and
  // returns the observed response; leaves the bench in the following IDLE cycle.
  task automatic applyStimulus(input logic [31:0] a_in, input logic [31:0] wd, input logic wr,
                               input logic [1:0] sz, input logic sgn,
                               output logic [31:0] got_rdata, output logic got_err,
                               output int got_lat, output int got_stall);
    int readies;
    addr      = a_in;
    wdata     = wd;
    rw        = wr;
    size      = sz;
    signed_ld = sgn;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    addr      = $urandom;
    wdata     = $urandom;
    rw        = 1'($urandom);
    size      = 2'($urandom);
    signed_ld = 1'($urandom);
    waitDone(got_lat, got_stall, readies);
    got_rdata = rdata;
    got_err   = misalign_err;
    checkOutput("stall_in_done", 32'(stall), 32'h0);
    tick();
    checkOutput("done_one_cycle", 32'(done), 32'h0);
    checkOutput("ready_after_done", 32'(req_ready), 32'h1);
  endtask

  // Runs one access and compares the DUT response against the reference model.
  task automatic runModelled(input string tag, input logic [31:0] a_in, input logic [31:0] wd,
                             input logic wr, input logic [1:0] sz, input logic sgn);
    logic [31:0] er, gr;
    logic        ee, ge;
    int          el, es, gl, gs;
    modelAccess(a_in, wd, wr, sz, sgn, er, ee, el, es);
    applyStimulus(a_in, wd, wr, sz, sgn, gr, ge, gl, gs);
    checkOutput({tag, "_rdata"}, gr, er);
    checkOutput({tag, "_err"}, 32'(ge), 32'(ee));
    checkOutput({tag, "_lat"}, 32'(gl), 32'(el));
    checkOutput({tag, "_stall"}, 32'(gs), 32'(es));
  endtask

  initial begin
    logic [31:0] gr, er, er2;
    logic        ge, ee;
    int          gl, gs, el, es, rd;
    logic [31:0] ra;
    logic [1:0]  rs;
    int          sel;

    compared    = 0;
    mismatched  = 0;
    model_rdata = 32'h0;
    model_cnt   = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    vecs[0]  = '{32'h10,       32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 32'h0,        1'b0, 5, 4};
    vecs[1]  = '{32'h10,       32'h0,        1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 5, 4};
    vecs[2]  = '{32'hABCD0010, 32'h0,        1'b0, 2'b10, 1'b1, 32'hDEADBEEF, 1'b0, 5, 4};
    vecs[3]  = '{32'h10,       32'h0,        1'b0, 2'b00, 1'b0, 32'h000000DE, 1'b0, 2, 1};
    vecs[4]  = '{32'h13,       32'h0,        1'b0, 2'b00, 1'b0, 32'h000000EF, 1'b0, 2, 1};
    vecs[5]  = '{32'h21,       32'hFFFFFF80, 1'b1, 2'b00, 1'b0, 32'h000000EF, 1'b0, 2, 1};
    vecs[6]  = '{32'h21,       32'h0,        1'b0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 2, 1};
    vecs[7]  = '{32'h21,       32'h0,        1'b0, 2'b00, 1'b0, 32'h00000080, 1'b0, 2, 1};
    vecs[8]  = '{32'h30,       32'h00001234, 1'b1, 2'b01, 1'b0, 32'h00000080, 1'b0, 3, 2};
    vecs[9]  = '{32'h30,       32'h0,        1'b0, 2'b01, 1'b1, 32'h00001234, 1'b0, 3, 2};
    vecs[10] = '{32'h30,       32'h0,        1'b0, 2'b00, 1'b1, 32'h00000012, 1'b0, 2, 1};
    vecs[11] = '{32'h31,       32'h0,        1'b0, 2'b00, 1'b1, 32'h00000034, 1'b0, 2, 1};
    vecs[12] = '{32'h13,       32'h0,        1'b0, 2'b10, 1'b0, 32'h0,        1'b1, 1, 0};
    vecs[13] = '{32'h30,       32'h0,        1'b0, 2'b01, 1'b1, 32'h00001234, 1'b0, 3, 2};
    vecs[14] = '{32'h00,       32'h0,        1'b0, 2'b11, 1'b0, 32'h0,        1'b1, 1, 0};
    vecs[15] = '{32'h31,       32'h5555AAAA, 1'b1, 2'b01, 1'b0, 32'h0,        1'b1, 1, 0};
    vecs[16] = '{32'hFC,       32'h8899AABB, 1'b1, 2'b10, 1'b0, 32'h0,        1'b0, 5, 4};
    vecs[17] = '{32'hFC,       32'h0,        1'b0, 2'b01, 1'b1, 32'hFFFF8899, 1'b0, 3, 2};
    vecs[18] = '{32'hFE,       32'h0,        1'b0, 2'b01, 1'b0, 32'h0000AABB, 1'b0, 3, 2};
    vecs[19] = '{32'hFC,       32'h0,        1'b0, 2'b10, 1'b0, 32'h8899AABB, 1'b0, 5, 4};
    vecs[20] = '{32'hFF,       32'h0,        1'b0, 2'b00, 1'b1, 32'hFFFFFFBB, 1'b0, 2, 1};
    vecs[21] = '{32'h12,       32'h0,        1'b0, 2'b10, 1'b0, 32'h0,        1'b1, 1, 0};

    reset     = 1'b1;
    req_valid = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    rw        = 1'b0;
    size      = 2'b00;
    signed_ld = 1'b0;
    tick();
    tick();
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_stall", 32'(stall), 32'h0);
    checkOutput("reset_err", 32'(misalign_err), 32'h0);
    checkOutput("reset_ready", 32'(req_ready), 32'h1);
`ifdef MEM_ACCESS_CNT_EN
    checkOutput("reset_cnt", 32'(access_cnt), 32'h0);
`endif
    reset = 1'b0;
    tick();

    $display("[TB] filling RAM with word stores");
    for (int k = 0; k < 64; k++) begin
      runModelled("fill", 32'(k * 4), $urandom, 1'b1, 2'b10, 1'b0);
    end

    $display("[TB] directed vector table");
    for (int i = 0; i < 22; i++) begin
      modelAccess(vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].size, vecs[i].sgn, er, ee, el, es);
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].size, vecs[i].sgn, gr, ge, gl, gs);
      checkOutput($sformatf("vec%0d_rdata", i), gr, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), 32'(ge), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_lat", i), 32'(gl), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d_stall", i), 32'(gs), 32'(vecs[i].exp_stall));
    end

    $display("[TB] reset during beat 2 of a word store");
    addr      = 32'h40;
    wdata     = 32'hAABBCCDD;
    rw        = 1'b1;
    size      = 2'b10;
    signed_ld = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checkOutput("midreset_stall_before", 32'(stall), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_ready", 32'(req_ready), 32'h1);
    checkOutput("midreset_stall", 32'(stall), 32'h0);
    checkOutput("midreset_done", 32'(done), 32'h0);
    checkOutput("midreset_err", 32'(misalign_err), 32'h0);
    checkOutput("midreset_rdata", rdata, 32'h0);
    model_mem[8'h40] = 8'hAA;
    model_mem[8'h41] = 8'hBB;
    model_rdata      = 32'h0;
    model_cnt        = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    tick();
    runModelled("postreset_w40", 32'h40, 32'h0, 1'b0, 2'b10, 1'b0);
    runModelled("postreset_b42", 32'h42, 32'h0, 1'b0, 2'b00, 1'b0);
    runModelled("postreset_mis", 32'h41, 32'h0, 1'b0, 2'b01, 1'b0);
`ifdef MEM_ACCESS_CNT_EN
    checkOutput("cnt_two_good", 32'(access_cnt), 32'd2);
`endif

    $display("[TB] back-to-back with request held during access");
    modelAccess(32'h10, 32'h0, 1'b0, 2'b10, 1'b0, er, ee, el, es);
    modelAccess(32'h21, 32'h0, 1'b0, 2'b00, 1'b1, er2, ee, el, es);
    addr      = 32'h10;
    rw        = 1'b0;
    size      = 2'b10;
    signed_ld = 1'b0;
    req_valid = 1'b1;
    tick();
    addr      = 32'h21;
    size      = 2'b00;
    signed_ld = 1'b1;
    waitDone(gl, gs, rd);
    checkOutput("b2b_first_lat", 32'(gl), 32'd5);
    checkOutput("b2b_first_rdata", rdata, er);
    checkOutput("b2b_ready_busy", 32'(rd), 32'd0);
    checkOutput("b2b_ready_in_done", 32'(req_ready), 32'h0);
    tick();
    checkOutput("b2b_idle_ready", 32'(req_ready), 32'h1);
    checkOutput("b2b_idle_done", 32'(done), 32'h0);
    tick();
    req_valid = 1'b0;
    waitDone(gl, gs, rd);
    checkOutput("b2b_second_lat", 32'(gl), 32'd2);
    checkOutput("b2b_second_rdata", rdata, er2);
    tick();

    $display("[TB] randomized accesses");
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      rs  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      ra  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'b01) ra[0] = 1'b0;
        if (rs == 2'b10) ra[1:0] = 2'b00;
      end
      runModelled($sformatf("rand%0d", k), ra, $urandom, 1'($urandom), rs, 1'($urandom));
    end
`ifdef MEM_ACCESS_CNT_EN
    checkOutput("cnt_final", 32'(access_cnt), 32'(model_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
